// File: rtl/ntru_pkg.sv
// ============================================================================
// Module   : ntru_pkg
// Purpose  : Shared constants and types for the NTRU-HRSS ternary convolution.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntru_pkg;

  localparam int N   = 701;
  localparam int Q_W = 13;

  typedef logic [Q_W-1:0] coef_t;
  typedef logic [1:0]     tern_t;

  // bit 0 = nonzero, bit 1 = negative
  localparam tern_t TERN_ZERO = 2'b00;
  localparam tern_t TERN_POS  = 2'b01;
  localparam tern_t TERN_NEG  = 2'b11;

  typedef enum logic [1:0] {
    LOAD_H = 2'd0,
    MAC    = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ternary_mac_lane.sv
// ============================================================================
// Module   : ternary_mac_lane
// Purpose  : One accumulator lane: e_next = e + t*h mod 2^Q_W, t in {-1,0,+1}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ternary_mac_lane
  import ntru_pkg::*;
#(
  parameter int Q_W = 13
) (
  input  logic [Q_W-1:0] e_i,
  input  logic [Q_W-1:0] h_i,
  input  tern_t          tern_i,
  output logic [Q_W-1:0] e_next_o
);

  logic           w_nz;
  logic           w_neg;
  logic [Q_W-1:0] w_operand;
  logic [Q_W-1:0] w_carry_in;

  assign w_nz       = tern_i[0];
  assign w_neg      = tern_i[1];
  // Two's-complement negation folded into the adder: invert, then carry in the sign.
  assign w_operand  = h_i ^ {Q_W{w_neg}};
  assign w_carry_in = {{(Q_W-1){1'b0}}, w_neg};
  assign e_next_o   = w_nz ? (e_i + w_operand + w_carry_in) : e_i;

endmodule

`default_nettype wire

// File: rtl/ternary_conv_engine.sv
// ============================================================================
// Module   : ternary_conv_engine
// Purpose  : Cyclic product e = r*h mod (x^N - 1), coefficients mod 2^Q_W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ternary_conv_engine #(
  parameter int N     = ntru_pkg::N,
  parameter int Q_W   = ntru_pkg::Q_W,
  parameter int CNT_W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           h_valid,
  output logic           h_ready,
  input  logic [Q_W-1:0] h_data,
  input  logic           r_valid,
  output logic           r_ready,
  input  logic [1:0]     r_data,
  output logic           e_valid,
  input  logic           e_ready,
  output logic [Q_W-1:0] e_data,
  output logic           busy,
  output logic           done
);

  import ntru_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [Q_W-1:0]   h_q [N];
  logic [Q_W-1:0]   e_q [N];
  logic [Q_W-1:0]   w_e_mac [N];

  logic w_h_fire;
  logic w_r_fire;
  logic w_e_fire;
  logic w_cnt_last;

  assign w_h_fire   = h_valid && (state_q == LOAD_H);
  assign w_r_fire   = r_valid && (state_q == MAC);
  assign w_e_fire   = e_ready && (state_q == DRAIN);
  assign w_cnt_last = (cnt_q == CNT_W'(N - 1));

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    ternary_mac_lane #(
      .Q_W (Q_W)
    ) u_lane (
      .e_i      (e_q[gi]),
      .h_i      (h_q[gi]),
      .tern_i   (r_data),
      .e_next_o (w_e_mac[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    h_ready = 1'b0;
    r_ready = 1'b0;
    e_valid = 1'b0;
    case (state_q)
      LOAD_H: begin
        h_ready = 1'b1;
        if (w_h_fire) begin
          if (w_cnt_last) begin
            cnt_d   = '0;
            state_d = MAC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      MAC: begin
        r_ready = 1'b1;
        if (w_r_fire) begin
          if (w_cnt_last) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        e_valid = 1'b1;
        if (w_e_fire) begin
          if (w_cnt_last) begin
            cnt_d   = '0;
            state_d = LOAD_H;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = LOAD_H;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_H;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // h: indexed load, then rotate one lane per accepted r beat.
  // e: MAC update per r beat, then shift toward lane 0 while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        h_q[i] <= '0;
        e_q[i] <= '0;
      end
    end else if (w_h_fire) begin
      for (int i = 0; i < N; i++) begin
        if (cnt_q == CNT_W'(i)) h_q[i] <= h_data;
      end
    end else if (w_r_fire) begin
      h_q[0] <= h_q[N-1];
      for (int i = 1; i < N; i++) h_q[i] <= h_q[i-1];
      for (int i = 0; i < N; i++) e_q[i] <= w_e_mac[i];
    end else if (w_e_fire) begin
      for (int i = 0; i < N - 1; i++) e_q[i] <= e_q[i+1];
      e_q[N-1] <= '0;
    end
  end

  assign e_data = (state_q == DRAIN) ? e_q[0] : '0;
  assign busy   = (state_q != LOAD_H) || (cnt_q != '0);
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ternary_conv_engine.sv
// ============================================================================
// Module   : tb_ternary_conv_engine
// Purpose  : Directed self-checking bench for ternary_conv_engine with N=5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ternary_conv_engine;

  localparam int N   = 5;
  localparam int Q_W = 13;
  localparam int MOD = 1 << Q_W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           h_valid = 1'b0;
  logic           h_ready;
  logic [Q_W-1:0] h_data = '0;
  logic           r_valid = 1'b0;
  logic           r_ready;
  logic [1:0]     r_data = 2'b00;
  logic           e_valid;
  logic           e_ready = 1'b0;
  logic [Q_W-1:0] e_data;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_pass   = 0;
  int sb[$];
  int hv[N];
  int rv[N];

  ternary_conv_engine #(
    .N   (N),
    .Q_W (Q_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .h_valid (h_valid),
    .h_ready (h_ready),
    .h_data  (h_data),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_data  (r_data),
    .e_valid (e_valid),
    .e_ready (e_ready),
    .e_data  (e_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // rv encoding: 1 -> +1, -1 -> -1, 0 -> zero, 2 -> the 2'b10 zero code
  function automatic logic [1:0] enc(input int v);
    case (v)
      1:       return 2'b01;
      -1:      return 2'b11;
      2:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push_expected();
    for (int i = 0; i < N; i++) begin
      int acc = 0;
      for (int j = 0; j < N; j++) begin
        int t = (rv[j] == 1) ? 1 : ((rv[j] == -1) ? -1 : 0);
        acc += t * hv[(i - j + N) % N];
      end
      sb.push_back(((acc % MOD) + MOD) % MOD);
    end
  endtask

  task automatic load_h();
    int k = 0;
    int budget = 0;
    while (k < N && budget < 100) begin
      @(negedge clk);
      e_ready = 1'b0;
      h_valid = 1'b1;
      h_data  = Q_W'(hv[k]);
      if (h_ready) k++;
      budget++;
    end
    check("h_beats", k, N);
  endtask

  task automatic feed_r(input int nbeats, input bit rand_valid);
    int k = 0;
    int budget = 0;
    while (k < nbeats && budget < 200) begin
      @(negedge clk);
      h_valid = 1'b0;
      r_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      r_data  = enc(rv[k]);
      if (r_valid && r_ready) k++;
      budget++;
    end
    check("r_beats", k, nbeats);
  endtask

  task automatic drain(input int stall_at, input bit tail);
    int k = 0;
    int budget = 0;
    int stalls = 0;
    while (k < N && budget < 200) begin
      @(negedge clk);
      r_valid = 1'b0;
      e_ready = !(k == stall_at && stalls < 3);
      if (!e_ready) stalls++;
      check("ready_excl", int'(h_ready && e_valid), 0);
      if (e_valid) begin
        if (e_ready) begin
          check($sformatf("e[%0d]", k), int'(e_data), sb.pop_front());
          k++;
        end else begin
          check($sformatf("e_stall[%0d]", k), int'(e_data), sb[0]);
        end
      end
      budget++;
    end
    check("e_beats", k, N);
    if (tail) begin
      @(negedge clk);
      e_ready = 1'b0;
      check("done_pulse", int'(done), 1);
      check("e_valid_after", int'(e_valid), 0);
      @(negedge clk);
      check("done_once", int'(done), 0);
      check("busy_idle", int'(busy), 0);
    end
  endtask

  task automatic run(input bit rand_valid, input int stall_at, input bit tail);
    push_expected();
    load_h();
    feed_r(N, rand_valid);
    drain(stall_at, tail);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_h_ready", int'(h_ready), 1);
    check("rst_r_ready", int'(r_ready), 0);
    check("rst_e_valid", int'(e_valid), 0);
    check("rst_e_data",  int'(e_data),  0);
    check("rst_busy",    int'(busy),    0);
    check("rst_done",    int'(done),    0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    hv = '{1, 2, 3, 4, 5};
    rv = '{1, 0, 0, 0, 0};
    run(1'b0, -1, 1'b1);
    rv = '{0, 1, 0, 0, 0};
    run(1'b0, -1, 1'b1);
    rv = '{0, 0, 0, 0, -1};
    run(1'b0, -1, 1'b1);

    hv = '{8191, 8191, 8191, 8191, 8191};
    rv = '{1, 1, 1, 1, 1};
    run(1'b0, -1, 1'b1);
    rv = '{2, 2, 2, 2, 2};
    run(1'b0, -1, 1'b1);

    hv = '{1, 2, 3, 4, 5};
    rv = '{1, -1, 0, 1, -1};
    run(1'b1, 2, 1'b1);

    // Abort mid-MAC with an off-edge reset, then a clean run.
    hv = '{7, 11, 13, 17, 19};
    rv = '{1, 1, -1, 0, 0};
    load_h();
    feed_r(3, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    r_valid = 1'b0;
    #1;
    check("abort_h_ready", int'(h_ready), 1);
    check("abort_r_ready", int'(r_ready), 0);
    check("abort_e_valid", int'(e_valid), 0);
    check("abort_busy",    int'(busy),    0);
    @(negedge clk);
    rst = 1'b0;
    hv = '{1, 0, 0, 0, 0};
    rv = '{-1, 1, 0, 0, 1};
    run(1'b0, -1, 1'b1);

    hv = '{3, 1, 4, 1, 5};
    rv = '{1, -1, 0, 1, -1};
    run(1'b0, -1, 1'b0);
    hv = '{9, 2, 6, 5, 3};
    rv = '{-1, -1, 1, 0, 1};
    run(1'b0, -1, 1'b1);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ternary_conv_engine.md
Name: ternary_conv_engine

Overview:
- Computes the cyclic product e = r*h mod (x^N - 1), with coefficients mod 2^Q_W, for the NTRU-HRSS encrypt path.
- h is a public-key polynomial and r is a ternary polynomial.
- Holds N accumulator lanes. Each lane performs the ternary add/subtract step e <= r ? e + (sign ? -h : h) : e.
- Sits between the key/randomness loaders (upstream streams) and the message-add/pack stage (downstream stream).

Parameters:
- N, 701: polynomial length (number of coefficients and lanes).
- Q_W, 13: coefficient width; arithmetic is mod 2^Q_W.
- CNT_W, $clog2(N): width of the beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- h_valid  in  1  h coefficient beat valid.
- h_ready  out  1  engine accepts h beat (LOAD_H only).
- h_data  in  Q_W  h coefficient; coefficient 0 first.
- r_valid  in  1  r coefficient beat valid.
- r_ready  out  1  engine accepts r beat (MAC only).
- r_data  in  2  ternary coefficient: [0] = nonzero, [1] = negative. 01 = +1, 11 = -1, 00 and 10 = 0.
- e_valid  out  1  result beat valid (DRAIN only).
- e_ready  in  1  downstream accepts result beat.
- e_data  out  Q_W  result coefficient; coefficient 0 first.
- busy  out  1  high whenever state != LOAD_H or cnt != 0.
- done  out  1  one-cycle pulse on acceptance of the last e beat.

Behaviour:
- Reset (async, active-high):
  - state = LOAD_H, cnt = 0.
  - All h_reg[i] = 0 and all e_reg[i] = 0.
  - h_ready = 1, r_ready = 0, e_valid = 0, e_data = 0, busy = 0, done = 0.
  - Asserting reset mid-operation aborts immediately; no partial output is emitted after release.
- Handshakes: a transfer occurs when valid && ready on a rising edge. Data is sampled only on transfer. No combinational path from any valid input to any ready output.
- LOAD_H:
  - h_ready = 1.
  - Each transfer writes h_reg[cnt] = h_data and increments cnt.
  - On transfer with cnt == N-1: cnt <= 0, state <= MAC.
  - e_reg is already all zero here (reset or drain shifts in zeros).
- MAC:
  - r_ready = 1.
  - Each transfer of r_j applies, for every lane i in parallel: e_reg[i] <= e_reg[i] + t_j*h_reg[i] mod 2^Q_W.
  - Negation is computed as (~h + 1), i.e. XOR with the sign followed by carry-in = sign.
  - In the same cycle h_reg rotates by one: h_reg[i] <= h_reg[(i-1) mod N].
  - Invariant before step j: h_reg[i] = h[(i-j) mod N].
  - r_valid low: hold all state, no rotation.
  - On transfer with cnt == N-1: cnt <= 0, state <= DRAIN. Latency is exactly N accepted r beats.
- DRAIN:
  - e_valid = 1, e_data = e_reg[0].
  - On transfer: e_reg shifts down (e_reg[i] <= e_reg[i+1], e_reg[N-1] <= 0) and cnt increments.
  - e_ready low: e_data and e_reg stay stable.
  - On transfer with cnt == N-1: done pulses the next cycle, state <= LOAD_H, cnt <= 0, e_reg is all zero.
- Arithmetic: all lane sums are truncated to Q_W bits; carry-out is discarded. Wrap-around from 2^Q_W - 1 to 0 is required.
- Inputs on non-active channels are ignored. The ready signals are mutually exclusive by state, so simultaneous h/r/e activity cannot transfer.
- Back-to-back operation: a new h stream can be accepted the cycle after the DRAIN-to-LOAD_H transition.

Decomposition:
- Shared package ntru_pkg:
  - Q_W and N constants.
  - typedef coef_t (logic [Q_W-1:0]).
  - typedef tern_t (logic [1:0]) with localparams TERN_ZERO = 2'b00, TERN_POS = 2'b01, TERN_NEG = 2'b11.
  - typedef enum state_t {LOAD_H, MAC, DRAIN}.
- One sub-module, ternary_mac_lane:
  - Inputs: e, h, tern. Output: e_next.
  - Purely combinational; instantiated N times via generate.
  - The top level owns all registers, the FSM and the counter.

Test Plan (N=5, Q_W=13 unless stated):
- h = [1,2,3,4,5], r = [+1,0,0,0,0] -> e = [1,2,3,4,5]; done pulses once; busy low afterwards.
- Same h, r = [0,+1,0,0,0] -> e = [5,1,2,3,4] (cyclic shift by x); r = [0,0,0,0,-1] -> e = [8190,8189,8188,8187,8191].
- h = all 8191, r = all +1 -> every e coefficient = 5*8191 mod 8192 = 8187 (wrap); r_data = 2'b10 on all beats -> e = all 0.
- Backpressure: r_valid toggled randomly and e_ready low for 3 cycles mid-drain -> e_data stable while stalled; e sequence identical to the unstalled run; exactly 5 e beats.
- Reset asserted asynchronously (off clock edge) after 3 r beats -> outputs return to reset values immediately. Then a full new run with h = [1,0,0,0,0], r = [-1,+1,0,0,+1] -> e = [8191,1,0,0,1] (no residue from the aborted run).
- Two back-to-back full runs with no idle cycles -> second result is correct; h_ready and e_valid never high together.
